// File: rtl/lottery_req_frontend_pkg.sv
// Shared types and sizing helpers for the lottery arbiter request front-end.
package lottery_req_frontend_pkg;

    localparam int unsigned N_DEF     = 4;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned DEST_W    = 2;
    localparam int unsigned LEN_W     = 4;

    // One queued packet: where it goes and how many cycles minus one it occupies.
    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [LEN_W-1:0]  len;
    } onoc_desc_t;

    typedef enum logic {
        StIdle,
        StXmit
    } tx_state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned src_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned SRC_W = src_w(N_DEF);

endpackage

// File: rtl/lottery_req_frontend_if.sv
// Bus bundle between the sources/arbiter/channel and the request front-end.
interface lottery_req_frontend_if
    import lottery_req_frontend_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned DW     = DEST_W,
    parameter int unsigned LW     = LEN_W
) ();

    localparam int unsigned SW = src_w(N);

    logic [N-1:0]    enq_valid;
    logic [N-1:0]    enq_ready;
    logic [N*DW-1:0] enq_dest;
    logic [N*LW-1:0] enq_len;
    logic [N-1:0]    request;
    logic [N-1:0]    grant;
    logic            tx_valid;
    logic [SW-1:0]   tx_src;
    logic [DW-1:0]   tx_dest;
    logic            tx_last;
    logic            busy;
    logic            grant_err;

    // Front-end side.
    modport slave (
        input  enq_valid, enq_dest, enq_len, grant,
        output enq_ready, request, tx_valid, tx_src, tx_dest, tx_last, busy, grant_err
    );

    // Environment side (sources, arbiter, channel).
    modport master (
        output enq_valid, enq_dest, enq_len, grant,
        input  enq_ready, request, tx_valid, tx_src, tx_dest, tx_last, busy, grant_err
    );

endinterface

// File: rtl/lottery_req_frontend_desc_fifo.sv
// Single-clock show-ahead FIFO of packet descriptors; one instance per source.
module lottery_req_frontend_desc_fifo
    import lottery_req_frontend_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  onoc_desc_t i_din,
    output onoc_desc_t o_dout,
    output logic       o_full,
    output logic       o_empty
);

    localparam int unsigned PTR_W = src_w(DEPTH);

    onoc_desc_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers wrap naturally; the extra count bit separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lottery_req_frontend.sv
// Per-source descriptor queues feeding a lottery arbiter, plus the channel
// occupancy counter that turns each granted descriptor into a transmit burst.
module lottery_req_frontend
    import lottery_req_frontend_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lottery_req_frontend_if.slave  bus
);

    localparam int unsigned SW = src_w(N);

    logic [N-1:0] w_full;
    logic [N-1:0] w_empty;
    logic [N-1:0] w_push;
    logic [N-1:0] w_pop;
    onoc_desc_t   w_din  [N];
    onoc_desc_t   w_head [N];

    tx_state_e         r_state;
    tx_state_e         w_state_nxt;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic [SW-1:0]     r_src;
    logic [SW-1:0]     w_src_nxt;
    logic [DEST_W-1:0] r_dest;
    logic [DEST_W-1:0] w_dest_nxt;
    logic              r_err;
    logic              w_err_nxt;

    logic          w_busy;
    logic          w_last;
    logic          w_slot;
    logic [N-1:0]  w_request;
    logic [N-1:0]  w_acc;
    logic          w_multi;
    logic          w_sel_found;
    logic [SW-1:0] w_sel_idx;

    for (genvar g = 0; g < N; g++) begin : g_src
        assign w_din[g]  = '{dest: bus.enq_dest[g*DEST_W +: DEST_W],
                             len:  bus.enq_len[g*LEN_W +: LEN_W]};
        assign w_push[g] = bus.enq_valid[g] && !w_full[g];

        lottery_req_frontend_desc_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_din   (w_din[g]),
            .o_dout  (w_head[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
    end

    // Requests come from registered state only, so the arbiter loop stays sequential.
    assign w_busy    = (r_state == StXmit);
    assign w_last    = w_busy && (r_cnt == '0);
    assign w_slot    = !w_busy || w_last;
    assign w_request = ~w_empty & {N{w_slot}};
    assign w_acc     = bus.grant & w_request;
    assign w_multi   = (w_acc & (w_acc - 1'b1)) != '0;

    // Lowest-index accepted grant wins; stray grant bits are simply masked off.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_pop       = '0;
        for (int i = 0; i < N; i++) begin
            if (w_acc[i] && !w_sel_found) begin
                w_sel_found = 1'b1;
                w_sel_idx   = SW'(i);
                w_pop[i]    = 1'b1;
            end
        end
    end

    // Transmit FSM: load on an accepted grant, otherwise count the burst down.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_src_nxt   = r_src;
        w_dest_nxt  = r_dest;
        w_err_nxt   = r_err | w_multi;
        unique case (r_state)
            StIdle: begin
                if (w_sel_found) begin
                    w_state_nxt = StXmit;
                    w_src_nxt   = w_sel_idx;
                    w_dest_nxt  = w_head[w_sel_idx].dest;
                    w_cnt_nxt   = w_head[w_sel_idx].len;
                end
            end
            StXmit: begin
                // A grant can only be accepted here in the last cycle: zero-bubble chaining.
                if (w_sel_found) begin
                    w_src_nxt  = w_sel_idx;
                    w_dest_nxt = w_head[w_sel_idx].dest;
                    w_cnt_nxt  = w_head[w_sel_idx].len;
                end else if (r_cnt == '0) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // FSM and transmit-context registers; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_src   <= '0;
            r_dest  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_src   <= w_src_nxt;
            r_dest  <= w_dest_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.enq_ready = ~w_full;
    assign bus.request   = w_request;
    assign bus.tx_valid  = w_busy;
    assign bus.busy      = w_busy;
    assign bus.tx_last   = w_last;
    assign bus.tx_src    = r_src;
    assign bus.tx_dest   = r_dest;
    assign bus.grant_err = r_err;

endmodule

// File: tb/tb_lottery_req_frontend.sv
// Randomised and directed bench for lottery_req_frontend against a queue-based model.
module tb_lottery_req_frontend;
    import lottery_req_frontend_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lottery_req_frontend_if #(.N(N), .DW(DEST_W), .LW(LEN_W)) bus ();

    lottery_req_frontend #(
        .N     (N),
        .DEPTH (DP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: per-source queues of {dest,len}, and cycles of channel time left.
    logic [5:0] mq [N][$];
    int         m_left;
    int         m_src;
    int         m_dest;
    logic       m_err;

    function automatic logic [N-1:0] m_request();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() != 0) && (m_left <= 1);
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_left = 0;
        m_src  = 0;
        m_dest = 0;
        m_err  = 1'b0;
    endtask

    task automatic check_outputs(input string ph);
        logic [N-1:0] rdy;
        for (int i = 0; i < N; i++) rdy[i] = mq[i].size() < DP;
        check({ph, ".request"},   32'(bus.request),   32'(m_request()));
        check({ph, ".enq_ready"}, 32'(bus.enq_ready), 32'(rdy));
        check({ph, ".tx_valid"},  32'(bus.tx_valid),  32'(m_left > 0));
        check({ph, ".busy"},      32'(bus.busy),      32'(m_left > 0));
        check({ph, ".tx_last"},   32'(bus.tx_last),   32'(m_left == 1));
        check({ph, ".grant_err"}, 32'(bus.grant_err), 32'(m_err));
        if (m_left > 0) begin
            check({ph, ".tx_src"},  32'(bus.tx_src),  32'(m_src));
            check({ph, ".tx_dest"}, 32'(bus.tx_dest), 32'(m_dest));
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model, clock, then check.
    task automatic step(input string ph, input logic [N-1:0] ev, input logic [N*DEST_W-1:0] ed,
                        input logic [N*LEN_W-1:0] el, input logic [N-1:0] gr);
        logic [N-1:0] req;
        logic [N-1:0] acc;
        logic [N-1:0] rdy;
        logic [5:0]   d;
        int           k;
        bus.enq_valid = ev;
        bus.enq_dest  = ed;
        bus.enq_len   = el;
        bus.grant     = gr;
        req = m_request();
        acc = gr & req;
        for (int i = 0; i < N; i++) rdy[i] = mq[i].size() < DP;
        if (acc != '0) begin
            k = 0;
            while (!acc[k]) k++;
            d      = mq[k].pop_front();
            m_left = int'(d[3:0]) + 1;
            m_src  = k;
            m_dest = int'(d[5:4]);
            if ($countones(acc) > 1) m_err = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
        end
        for (int i = 0; i < N; i++) begin
            if (ev[i] && rdy[i]) mq[i].push_back({ed[i*DEST_W +: DEST_W], el[i*LEN_W +: LEN_W]});
        end
        @(posedge clk);
        @(negedge clk);
        bus.enq_valid = '0;
        bus.grant     = '0;
        check_outputs(ph);
    endtask

    task automatic do_reset(input string ph);
        rst_n         = 1'b0;
        bus.enq_valid = '0;
        bus.enq_dest  = '0;
        bus.enq_len   = '0;
        bus.grant     = '0;
        m_reset();
        #1;
        check_outputs(ph);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_outputs({ph, ".rel"});
    endtask

    task automatic random_phase(input string ph, input int cycles);
        logic [N-1:0] gr;
        logic [N-1:0] ev;
        int           idx;
        int           sel;
        for (int c = 0; c < cycles; c++) begin
            idx = $urandom_range(0, N - 1);
            sel = $urandom_range(0, 19);
            if (sel < 12)       gr = N'(1 << idx);
            else if (sel == 12) gr = N'($urandom);
            else                gr = '0;
            for (int i = 0; i < N; i++) ev[i] = ($urandom_range(0, 2) == 0);
            step(ph, ev, (N*DEST_W)'($urandom), (N*LEN_W)'($urandom), gr);
        end
    endtask

    int vcnt;
    int lcnt;

    initial begin
        m_reset();
        @(negedge clk);
        do_reset("reset");
        for (int c = 0; c < 10; c++) step("idle", '0, '0, '0, '0);

        // Single packet: src2, dest 1, len 3 -> four channel cycles.
        step("single", 4'b0100, 8'h10, 16'h0300, '0);
        check("single.req_up", 32'(bus.request), 32'h4);
        step("single", '0, '0, '0, 4'b0100);
        check("single.first_valid", 32'(bus.tx_valid), 32'h1);
        check("single.src", 32'(bus.tx_src), 32'h2);
        check("single.dest", 32'(bus.tx_dest), 32'h1);
        check("single.req_down", 32'(bus.request), 32'h0);
        lcnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.tx_last) lcnt++;
            step("single", '0, '0, '0, '0);
        end
        check("single.last_at_end", 32'(bus.tx_last), 32'h1);
        check("single.early_last", 32'(lcnt), 32'h0);
        step("single", '0, '0, '0, '0);
        check("single.done", 32'(bus.tx_valid), 32'h0);

        // Back-to-back from src0: len 1 then len 0, no bubble.
        step("b2b", 4'b0001, '0, 16'h0001, '0);
        step("b2b", 4'b0001, '0, 16'h0000, '0);
        vcnt = 0;
        lcnt = 0;
        for (int c = 0; c < 4; c++) begin
            step("b2b", '0, '0, '0, m_request() & 4'b0001);
            if (bus.tx_valid) vcnt++;
            if (bus.tx_last)  lcnt++;
        end
        check("b2b.valid_cycles", 32'(vcnt), 32'h3);
        check("b2b.last_cycles", 32'(lcnt), 32'h2);

        // Backpressure and wrap on src1.
        for (int c = 0; c < 4; c++) begin
            step("fill", 4'b0010, (N*DEST_W)'($urandom), '0, '0);
        end
        check("fill.ready1", 32'(bus.enq_ready[1]), 32'h0);
        for (int c = 0; c < 10; c++) begin
            step("wrap", (c < 4) ? 4'b0010 : 4'b0000, (N*DEST_W)'($urandom),
                 (N*LEN_W)'($urandom) & 16'h0010, m_request() & 4'b0010);
        end

        // Grant robustness.
        do_reset("gerr_rst");
        step("stray", '0, '0, '0, 4'b1000);
        check("stray.no_err", 32'(bus.grant_err), 32'h0);
        step("gerr", 4'b0011, 8'h06, '0, '0);
        step("gerr", '0, '0, '0, 4'b0011);
        check("gerr.flag", 32'(bus.grant_err), 32'h1);
        check("gerr.src0", 32'(bus.tx_src), 32'h0);
        for (int c = 0; c < 4; c++) step("gerr_hold", '0, '0, '0, '0);
        check("gerr.sticky", 32'(bus.grant_err), 32'h1);

        // Reset during the second cycle of a len=5 packet.
        do_reset("mid_rst0");
        step("mid", 4'b1001, '0, 16'h5002, '0);
        step("mid", '0, '0, '0, 4'b1000);
        step("mid", '0, '0, '0, '0);
        check("mid.in_packet", 32'(bus.tx_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.valid_drop", 32'(bus.tx_valid), 32'h0);
        check("mid.busy_drop", 32'(bus.busy), 32'h0);
        check("mid.no_last", 32'(bus.tx_last), 32'h0);
        m_reset();
        @(negedge clk);
        do_reset("mid_rst1");

        random_phase("rand_a", 1500);
        do_reset("rand_rst");
        random_phase("rand_b", 1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
